// File: rtl/mispred_recovery_ctrl_pkg.sv
// Shared types for mispredict recovery: FSM states, ROB tag and address types.
// ROB_ID_WIDTH may be set on the command line; by default it describes an 8-entry ROB.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 3
`endif

package mispred_recovery_ctrl_pkg;

    localparam int AGE_CMP_W = `ROB_ID_WIDTH;

    typedef logic [AGE_CMP_W-1:0] rob_id_t;
    typedef logic [31:0]          addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RETIRE,
        ST_FLUSH,
        ST_REDIRECT
    } recovery_state_t;

endpackage

// File: rtl/mispred_recovery_ctrl_rob_age_cmp.sv
// Wrap-aware ROB age compare: a_older is set when a is strictly older than b
// relative to the current ROB head. Shared with the LSQ.
module rob_age_cmp
    import mispred_recovery_ctrl_pkg::*;
#(
    parameter int W = AGE_CMP_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] head,
    output logic         a_older
);

    logic [W-1:0] age_a;
    logic [W-1:0] age_b;

    always_comb begin
        age_a   = a - head;
        age_b   = b - head;
        a_older = (age_a < age_b);
    end

endmodule

// File: rtl/mispred_recovery_ctrl.sv
// Branch/load mispredict recovery: wait for the offender to retire, flush, redirect fetch.
// Define RECOVERY_PERF_CNT_EN to add saturating recovery and stall-cycle counters.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 3
`endif

module mispred_recovery_ctrl
    import mispred_recovery_ctrl_pkg::*;
#(
    parameter int ROB_ID_W = `ROB_ID_WIDTH
) (
    input  logic                clk,
    input  logic                rst_aL,
    input  logic                alu_br_mispred,
    input  logic [ROB_ID_W-1:0] alu_br_rob_id,
    input  addr_t               alu_br_npc,
    input  logic                ld_mispred,
    input  logic [ROB_ID_W-1:0] ld_rob_id,
    input  addr_t               ld_pc,
    input  logic [ROB_ID_W-1:0] rob_head_rob_id,
    input  logic                rob_retire,
    input  logic [ROB_ID_W-1:0] rob_retire_rob_id,
    output logic                dispatch_stall,
    output logic                flush_all,
    output logic                fetch_redirect_valid,
    output addr_t               fetch_redirect_pc,
    input  logic                fetch_redirect_ready,
    output logic                busy
`ifdef RECOVERY_PERF_CNT_EN
    ,
    output logic [31:0]         perf_recover_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    recovery_state_t     state;
    logic [ROB_ID_W-1:0] tgt_rob_id;
    addr_t               tgt_pc;

    logic                any_mispred;
    logic                ld_older;
    logic                cand_older;
    logic                retire_hit;
    logic [ROB_ID_W-1:0] cand_rob_id;
    addr_t               cand_pc;

    // Pick the older of two simultaneous mispredicts; ties go to the ALU.
    rob_age_cmp #(.W(ROB_ID_W)) u_sel_cmp (
        .a       (ld_rob_id),
        .b       (alu_br_rob_id),
        .head    (rob_head_rob_id),
        .a_older (ld_older)
    );

    rob_age_cmp #(.W(ROB_ID_W)) u_repl_cmp (
        .a       (cand_rob_id),
        .b       (tgt_rob_id),
        .head    (rob_head_rob_id),
        .a_older (cand_older)
    );

    always_comb begin
        any_mispred = alu_br_mispred | ld_mispred;
        if (ld_mispred && (!alu_br_mispred || ld_older)) begin
            cand_rob_id = ld_rob_id;
            cand_pc     = ld_pc;
        end else begin
            cand_rob_id = alu_br_rob_id;
            cand_pc     = alu_br_npc;
        end
        retire_hit = rob_retire && (rob_retire_rob_id == tgt_rob_id);
    end

    assign busy           = (state != ST_IDLE);
    assign dispatch_stall = rst_aL & (busy | any_mispred);

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state                <= ST_IDLE;
            tgt_rob_id           <= '0;
            tgt_pc               <= '0;
            flush_all            <= 1'b0;
            fetch_redirect_valid <= 1'b0;
            fetch_redirect_pc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_mispred) begin
                        tgt_rob_id <= cand_rob_id;
                        tgt_pc     <= cand_pc;
                        state      <= ST_WAIT_RETIRE;
                    end
                end
                ST_WAIT_RETIRE: begin
                    // A retiring target outranks any replacement: the newcomer is younger.
                    if (retire_hit) begin
                        flush_all <= 1'b1;
                        state     <= ST_FLUSH;
                    end else if (any_mispred && cand_older) begin
                        tgt_rob_id <= cand_rob_id;
                        tgt_pc     <= cand_pc;
                    end
                end
                ST_FLUSH: begin
                    flush_all            <= 1'b0;
                    fetch_redirect_valid <= 1'b1;
                    fetch_redirect_pc    <= tgt_pc;
                    state                <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (fetch_redirect_ready) begin
                        fetch_redirect_valid <= 1'b0;
                        fetch_redirect_pc    <= '0;
                        state                <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RECOVERY_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            perf_recover_cnt <= '0;
            perf_stall_cnt   <= '0;
        end else begin
            if (state == ST_FLUSH) perf_recover_cnt <= sat_inc(perf_recover_cnt);
            if (dispatch_stall)    perf_stall_cnt   <= sat_inc(perf_stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_mispred_recovery_ctrl.sv
// Directed bench for mispred_recovery_ctrl with an 8-entry ROB (3-bit tags).
module tb_mispred_recovery_ctrl;

    logic        clk;
    logic        rst_aL;
    logic        alu_br_mispred;
    logic [2:0]  alu_br_rob_id;
    logic [31:0] alu_br_npc;
    logic        ld_mispred;
    logic [2:0]  ld_rob_id;
    logic [31:0] ld_pc;
    logic [2:0]  rob_head_rob_id;
    logic        rob_retire;
    logic [2:0]  rob_retire_rob_id;
    logic        dispatch_stall;
    logic        flush_all;
    logic        fetch_redirect_valid;
    logic [31:0] fetch_redirect_pc;
    logic        fetch_redirect_ready;
    logic        busy;
`ifdef RECOVERY_PERF_CNT_EN
    logic [31:0] perf_recover_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int flush_pulses = 0;

    mispred_recovery_ctrl #(.ROB_ID_W(3)) dut (
        .clk                  (clk),
        .rst_aL               (rst_aL),
        .alu_br_mispred       (alu_br_mispred),
        .alu_br_rob_id        (alu_br_rob_id),
        .alu_br_npc           (alu_br_npc),
        .ld_mispred           (ld_mispred),
        .ld_rob_id            (ld_rob_id),
        .ld_pc                (ld_pc),
        .rob_head_rob_id      (rob_head_rob_id),
        .rob_retire           (rob_retire),
        .rob_retire_rob_id    (rob_retire_rob_id),
        .dispatch_stall       (dispatch_stall),
        .flush_all            (flush_all),
        .fetch_redirect_valid (fetch_redirect_valid),
        .fetch_redirect_pc    (fetch_redirect_pc),
        .fetch_redirect_ready (fetch_redirect_ready),
        .busy                 (busy)
`ifdef RECOVERY_PERF_CNT_EN
        ,
        .perf_recover_cnt     (perf_recover_cnt),
        .perf_stall_cnt       (perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (flush_all === 1'b1) flush_pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_br_mispred       = 1'b0;
        alu_br_rob_id        = '0;
        alu_br_npc           = '0;
        ld_mispred           = 1'b0;
        ld_rob_id            = '0;
        ld_pc                = '0;
        rob_head_rob_id      = '0;
        rob_retire           = 1'b0;
        rob_retire_rob_id    = '0;
        fetch_redirect_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_aL = 1'b0;
        clear_inputs();
        tick();
        tick();
        tests++; if (flush_all !== 1'b0) begin fails++; $display("FAIL reset_flush: got %b want 0", flush_all); end
        tests++; if (fetch_redirect_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", fetch_redirect_valid); end
        tests++; if (fetch_redirect_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", fetch_redirect_pc); end
        tests++; if (dispatch_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", dispatch_stall); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_aL = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int p0;
        rob_head_rob_id = 3'd3;
        alu_br_mispred = 1'b1; alu_br_rob_id = 3'd5; alu_br_npc = 32'h100;
        #1;
        tests++; if (dispatch_stall !== 1'b1) begin fails++; $display("FAIL basic_comb_stall: got %b want 1", dispatch_stall); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
        tick();
        alu_br_mispred = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_wait_busy: got %b want 1", busy); end
        tests++; if (dispatch_stall !== 1'b1) begin fails++; $display("FAIL basic_wait_stall: got %b want 1", dispatch_stall); end
        tick();
        tests++; if (flush_all !== 1'b0) begin fails++; $display("FAIL basic_early_flush: got %b want 0", flush_all); end
        p0 = flush_pulses;
        rob_retire = 1'b1; rob_retire_rob_id = 3'd5;
        tick();
        rob_retire = 1'b0;
        tests++; if (flush_all !== 1'b1) begin fails++; $display("FAIL basic_flush: got %b want 1", flush_all); end
        tick();
        tests++; if (flush_all !== 1'b0) begin fails++; $display("FAIL basic_flush_end: got %b want 0", flush_all); end
        tests++; if (fetch_redirect_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", fetch_redirect_valid); end
        tests++; if (fetch_redirect_pc !== 32'h100) begin fails++; $display("FAIL basic_pc: got %h want 100", fetch_redirect_pc); end
        fetch_redirect_ready = 1'b1;
        tick();
        fetch_redirect_ready = 1'b0;
        tests++; if (fetch_redirect_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop: got %b want 0", fetch_redirect_valid); end
        tests++; if (dispatch_stall !== 1'b0) begin fails++; $display("FAIL basic_stall_clear: got %b want 0", dispatch_stall); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_clear: got %b want 0", busy); end
        tests++; if (flush_pulses - p0 !== 1) begin fails++; $display("FAIL basic_pulse_count: got %0d want 1", flush_pulses - p0); end
    endtask

    task automatic test_latency();
        rob_head_rob_id = 3'd0;
        alu_br_mispred = 1'b1; alu_br_rob_id = 3'd0; alu_br_npc = 32'h40;
        tick();
        alu_br_mispred = 1'b0;
        rob_retire = 1'b1; rob_retire_rob_id = 3'd0;
        tests++; if (flush_all !== 1'b0) begin fails++; $display("FAIL lat_t1_flush: got %b want 0", flush_all); end
        tick();
        rob_retire = 1'b0;
        tests++; if (flush_all !== 1'b1) begin fails++; $display("FAIL lat_t2_flush: got %b want 1", flush_all); end
        tests++; if (fetch_redirect_valid !== 1'b0) begin fails++; $display("FAIL lat_t2_valid: got %b want 0", fetch_redirect_valid); end
        tick();
        tests++; if (fetch_redirect_valid !== 1'b1) begin fails++; $display("FAIL lat_t3_valid: got %b want 1", fetch_redirect_valid); end
        tests++; if (fetch_redirect_pc !== 32'h40) begin fails++; $display("FAIL lat_t3_pc: got %h want 40", fetch_redirect_pc); end
        fetch_redirect_ready = 1'b1;
        tick();
        fetch_redirect_ready = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL lat_idle: got %b want 0", busy); end
    endtask

    task automatic test_select();
        // Head 6: ALU id 1 has age 3, LD id 7 has age 1, so the load wins.
        rob_head_rob_id = 3'd6;
        alu_br_mispred = 1'b1; alu_br_rob_id = 3'd1; alu_br_npc = 32'h300;
        ld_mispred = 1'b1; ld_rob_id = 3'd7; ld_pc = 32'h200;
        tick();
        alu_br_mispred = 1'b0; ld_mispred = 1'b0;
        rob_retire = 1'b1; rob_retire_rob_id = 3'd7;
        tick();
        rob_retire = 1'b0;
        tick();
        tests++; if (fetch_redirect_pc !== 32'h200) begin fails++; $display("FAIL sel_ld_older_pc: got %h want 200", fetch_redirect_pc); end
        fetch_redirect_ready = 1'b1;
        tick();
        fetch_redirect_ready = 1'b0;
        // Equal age: ALU wins.
        alu_br_mispred = 1'b1; alu_br_rob_id = 3'd2; alu_br_npc = 32'h11;
        ld_mispred = 1'b1; ld_rob_id = 3'd2; ld_pc = 32'h22;
        tick();
        alu_br_mispred = 1'b0; ld_mispred = 1'b0;
        rob_retire = 1'b1; rob_retire_rob_id = 3'd2;
        tick();
        rob_retire = 1'b0;
        tick();
        tests++; if (fetch_redirect_pc !== 32'h11) begin fails++; $display("FAIL sel_tie_alu_pc: got %h want 11", fetch_redirect_pc); end
        fetch_redirect_ready = 1'b1;
        tick();
        fetch_redirect_ready = 1'b0;
    endtask

    task automatic test_replace();
        rob_head_rob_id = 3'd2;
        alu_br_mispred = 1'b1; alu_br_rob_id = 3'd4; alu_br_npc = 32'h400;
        tick();
        alu_br_mispred = 1'b0;
        ld_mispred = 1'b1; ld_rob_id = 3'd3; ld_pc = 32'h80;
        tick();
        ld_mispred = 1'b0;
        alu_br_mispred = 1'b1; alu_br_rob_id = 3'd5; alu_br_npc = 32'h500;
        tick();
        alu_br_mispred = 1'b0;
        rob_retire = 1'b1; rob_retire_rob_id = 3'd4;
        tick();
        rob_retire = 1'b0;
        tests++; if (flush_all !== 1'b0) begin fails++; $display("FAIL repl_old_tgt_flush: got %b want 0", flush_all); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL repl_still_wait: got %b want 1", busy); end
        rob_retire = 1'b1; rob_retire_rob_id = 3'd3;
        tick();
        rob_retire = 1'b0;
        tests++; if (flush_all !== 1'b1) begin fails++; $display("FAIL repl_flush: got %b want 1", flush_all); end
        tick();
        tests++; if (fetch_redirect_pc !== 32'h80) begin fails++; $display("FAIL repl_pc: got %h want 80", fetch_redirect_pc); end
        fetch_redirect_ready = 1'b1;
        tick();
        fetch_redirect_ready = 1'b0;
    endtask

    task automatic test_retire_wins();
        rob_head_rob_id = 3'd0;
        alu_br_mispred = 1'b1; alu_br_rob_id = 3'd2; alu_br_npc = 32'hA0;
        tick();
        alu_br_mispred = 1'b0;
        rob_retire = 1'b1; rob_retire_rob_id = 3'd2;
        ld_mispred = 1'b1; ld_rob_id = 3'd1; ld_pc = 32'hB0;
        tick();
        rob_retire = 1'b0; ld_mispred = 1'b0;
        tests++; if (flush_all !== 1'b1) begin fails++; $display("FAIL rw_flush: got %b want 1", flush_all); end
        tick();
        tests++; if (fetch_redirect_pc !== 32'hA0) begin fails++; $display("FAIL rw_pc: got %h want a0", fetch_redirect_pc); end
        fetch_redirect_ready = 1'b1;
        tick();
        fetch_redirect_ready = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rw_idle: got %b want 0", busy); end
    endtask

    task automatic test_ready_hold();
        int p0;
        p0 = flush_pulses;
        rob_head_rob_id = 3'd0;
        alu_br_mispred = 1'b1; alu_br_rob_id = 3'd0; alu_br_npc = 32'hC0;
        tick();
        alu_br_mispred = 1'b0;
        rob_retire = 1'b1; rob_retire_rob_id = 3'd0;
        tick();
        rob_retire = 1'b0;
        tick();
        // Mispredicts arriving while redirecting must not disturb the target.
        for (int i = 0; i < 5; i++) begin
            alu_br_mispred = 1'b1; alu_br_rob_id = 3'd0; alu_br_npc = 32'hDEAD;
            tests++; if (fetch_redirect_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d]: got %b want 1", i, fetch_redirect_valid); end
            tests++; if (fetch_redirect_pc !== 32'hC0) begin fails++; $display("FAIL hold_pc[%0d]: got %h want c0", i, fetch_redirect_pc); end
            tick();
        end
        alu_br_mispred = 1'b0;
        fetch_redirect_ready = 1'b1;
        tick();
        fetch_redirect_ready = 1'b0;
        tests++; if (fetch_redirect_valid !== 1'b0) begin fails++; $display("FAIL hold_release: got %b want 0", fetch_redirect_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_idle: got %b want 0", busy); end
        tests++; if (flush_pulses - p0 !== 1) begin fails++; $display("FAIL hold_pulse_count: got %0d want 1", flush_pulses - p0); end
    endtask

    task automatic test_reset_mid();
        rob_head_rob_id = 3'd0;
        alu_br_mispred = 1'b1; alu_br_rob_id = 3'd1; alu_br_npc = 32'hE0;
        tick();
        alu_br_mispred = 1'b0;
        rob_retire = 1'b1; rob_retire_rob_id = 3'd1;
        tick();
        rob_retire = 1'b0;
        tick();
        tests++; if (fetch_redirect_valid !== 1'b1) begin fails++; $display("FAIL rstm_pre_valid: got %b want 1", fetch_redirect_valid); end
        rst_aL = 1'b0;
        #1;
        tests++; if (fetch_redirect_valid !== 1'b0) begin fails++; $display("FAIL rstm_valid: got %b want 0", fetch_redirect_valid); end
        tests++; if (fetch_redirect_pc !== 32'h0) begin fails++; $display("FAIL rstm_pc: got %h want 0", fetch_redirect_pc); end
        tests++; if (flush_all !== 1'b0) begin fails++; $display("FAIL rstm_flush: got %b want 0", flush_all); end
        tests++; if (dispatch_stall !== 1'b0) begin fails++; $display("FAIL rstm_stall: got %b want 0", dispatch_stall); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstm_busy: got %b want 0", busy); end
        tick();
        #2 rst_aL = 1'b1;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstm_post_idle: got %b want 0", busy); end
        alu_br_mispred = 1'b1; alu_br_rob_id = 3'd3; alu_br_npc = 32'hF0;
        tick();
        alu_br_mispred = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstm_accept: got %b want 1", busy); end
        rob_retire = 1'b1; rob_retire_rob_id = 3'd3;
        tick();
        rob_retire = 1'b0;
        tests++; if (flush_all !== 1'b1) begin fails++; $display("FAIL rstm_flush2: got %b want 1", flush_all); end
        tick();
        tests++; if (fetch_redirect_pc !== 32'hF0) begin fails++; $display("FAIL rstm_pc2: got %h want f0", fetch_redirect_pc); end
        fetch_redirect_ready = 1'b1;
        tick();
        fetch_redirect_ready = 1'b0;
    endtask

`ifdef RECOVERY_PERF_CNT_EN
    task automatic test_perf();
        rst_aL = 1'b0;
        tick();
        rst_aL = 1'b1;
        tick();
        tests++; if (perf_recover_cnt !== 32'd0) begin fails++; $display("FAIL perf_rec_reset: got %0d want 0", perf_recover_cnt); end
        tests++; if (perf_stall_cnt !== 32'd0) begin fails++; $display("FAIL perf_stall_reset: got %0d want 0", perf_stall_cnt); end
        // Each recovery stalls 4 cycles: mispredict, wait, flush, redirect.
        for (int r = 0; r < 2; r++) begin
            rob_head_rob_id = 3'd0;
            alu_br_mispred = 1'b1; alu_br_rob_id = 3'd0; alu_br_npc = 32'h10;
            tick();
            alu_br_mispred = 1'b0;
            rob_retire = 1'b1; rob_retire_rob_id = 3'd0;
            tick();
            rob_retire = 1'b0;
            tick();
            fetch_redirect_ready = 1'b1;
            tick();
            fetch_redirect_ready = 1'b0;
            tick();
        end
        tests++; if (perf_recover_cnt !== 32'd2) begin fails++; $display("FAIL perf_rec_cnt: got %0d want 2", perf_recover_cnt); end
        tests++; if (perf_stall_cnt !== 32'd8) begin fails++; $display("FAIL perf_stall_cnt: got %0d want 8", perf_stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_select();
        test_replace();
        test_retire_wins();
        test_ready_hold();
        test_reset_mid();
`ifdef RECOVERY_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
